// File: rtl/mips_pkg.sv
// Shared types for the MIPS-I decode stage: instruction classes, opcodes, decoded payload.
// Payload XLEN fields are sized for the widest legal XLEN; narrower builds use the low bits.
package mips_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        CLS_R     = 3'd0,
        CLS_J     = 3'd1,
        CLS_BR    = 3'd2,
        CLS_LD    = 3'd3,
        CLS_ST    = 3'd4,
        CLS_ALUI  = 3'd5,
        CLS_OTHER = 3'd6
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } skid_state_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [5:0]          opcode;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [4:0]          shamt;
        logic [5:0]          funct;
        logic [XLEN_MAX-1:0] imm;
        logic [XLEN_MAX-1:0] jtarget;
        instr_class_e        cls;
        logic                illegal;
    } decoded_t;

    function automatic logic funct_implemented(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
            6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_field_decode.sv
// Field split, immediate extension, jump target and class of one instruction.
// Latency: combinational. Backpressure: none, pure function of instr/pc.
// Illegal flag is always computed; the stage decides whether to expose it.
module mips_field_decode
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output decoded_t        dec
);

    logic [5:0]       opcode;
    logic [15:0]      imm16;
    logic [XLEN-1:28] pc4_hi;
    instr_class_e     cls;

    assign opcode = instr[31:26];
    assign imm16  = instr[15:0];

    // Only the top bits of pc+4 reach the target: carry into bit 28 iff pc[27:2] is all ones.
    assign pc4_hi = pc[XLEN-1:28] + (XLEN-28)'(&pc[27:2]);

    always_comb begin
        cls = CLS_OTHER;
        case (opcode) inside
            OP_RTYPE:              cls = CLS_R;
            [OP_J:OP_JAL]:         cls = CLS_J;
            OP_REGIMM,
            [OP_BEQ:OP_BGTZ]:      cls = CLS_BR;
            [OP_LB:OP_LHU]:        cls = CLS_LD;
            OP_SB, OP_SH, OP_SW:   cls = CLS_ST;
            [OP_ADDI:OP_LUI]:      cls = CLS_ALUI;
            default:               cls = CLS_OTHER;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = XLEN_MAX'(pc);
        dec.opcode  = opcode;
        dec.rs      = instr[25:21];
        dec.rt      = instr[20:16];
        dec.rd      = instr[15:11];
        dec.shamt   = instr[10:6];
        dec.funct   = instr[5:0];
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: dec.imm = {48'h0, imm16};
            OP_LUI:                   dec.imm = {{32{imm16[15]}}, imm16, 16'h0};
            default:                  dec.imm = {{48{imm16[15]}}, imm16};
        endcase
        dec.jtarget = XLEN_MAX'({pc4_hi, instr[25:0], 2'b00});
        dec.cls     = cls;
        dec.illegal = (cls == CLS_OTHER) ||
                      ((cls == CLS_R) && !funct_implemented(instr[5:0]));
    end

endmodule

// File: rtl/mips_decode_stage.sv
// Registered MIPS-I decode stage with a 2-entry skid; optional out_illegal via DECODE_ILLEGAL_EN.
// Latency: 1 cycle accept to out_valid. Backpressure: holds up to 2, in_ready=0 only when both full.
// flush empties the stage on the next edge and drops any instruction offered in that cycle.
module mips_decode_stage
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_jtarget,
`ifdef DECODE_ILLEGAL_EN
    output logic            out_illegal,
`endif
    output logic [2:0]      out_class
);

    skid_state_e state_q, state_d;
    decoded_t    dec, out_q, skid_q;
    logic        accept, drain, load_out, load_skid, from_skid;

    mips_field_decode #(.XLEN(XLEN)) u_field_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec)
    );

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    load_out = 1'b1;
                    state_d  = ST_ONE;
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        load_skid = 1'b1;
                        state_d   = ST_TWO;
                    end else if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (drain) begin
                    load_out  = 1'b1;
                    from_skid = 1'b1;
                    state_d   = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out)  out_q  <= from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign out_pc      = out_q.pc[XLEN-1:0];
    assign out_opcode  = out_q.opcode;
    assign out_rs      = out_q.rs;
    assign out_rt      = out_q.rt;
    assign out_rd      = out_q.rd;
    assign out_shamt   = out_q.shamt;
    assign out_funct   = out_q.funct;
    assign out_imm     = out_q.imm[XLEN-1:0];
    assign out_jtarget = out_q.jtarget[XLEN-1:0];
    assign out_class   = out_q.cls;

`ifdef DECODE_ILLEGAL_EN
    assign out_illegal = out_q.illegal;
    logic unused_hi;
    assign unused_hi = ^{out_q.pc >> XLEN, out_q.imm >> XLEN, out_q.jtarget >> XLEN};
`else
    logic unused_hi;
    assign unused_hi = ^{out_q.pc >> XLEN, out_q.imm >> XLEN, out_q.jtarget >> XLEN,
                         out_q.illegal};
`endif

endmodule
